// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one operand bit per clock,
// registered result presented with a one-cycle done pulse.
module bin_to_bcd_serial #(
   parameter int WIDTH  = 7,
   parameter int DIGITS = 3
) (
   input  logic                  CLK100MHZ,
   input  logic                  RST,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BCD_W-1:0]   corrected;

   // Add 3 to every digit >= 5; each digit is corrected independently, no carry.
   function automatic logic [BCD_W-1:0] dabble_correct(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      logic [3:0]       d;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         d = s[4*i +: 4];
         r[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
      end
      return r;
   endfunction

   assign corrected = dabble_correct(scratch_q);

   always_comb begin
      state_d   = state_q;
      bin_sr_d  = bin_sr_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_sr_d  = bin;
               scratch_d = '0;
               cnt_d     = CNT_W'(WIDTH);
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Operand MSB shifts into the corrected BCD accumulator.
            scratch_d = {corrected[BCD_W-2:0], bin_sr_q[WIDTH-1]};
            bin_sr_d  = {bin_sr_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            // No correction after the last shift: scratch already holds the result.
            bcd_d   = scratch_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state_q   <= IDLE;
         bin_sr_q  <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         state_q   <= state_d;
         bin_sr_q  <= bin_sr_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial against a decimal-arithmetic model.
module tb_bin_to_bcd_serial;

   logic        clk;
   logic        rst;
   logic        start;
   logic [6:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;

   int n_vec = 0;
   int n_err = 0;

   bin_to_bcd_serial #(.WIDTH(7), .DIGITS(3)) dut (
      .CLK100MHZ (clk),
      .RST       (rst),
      .start     (start),
      .bin       (bin),
      .busy      (busy),
      .done      (done),
      .bcd       (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] ref_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Runs one start pulse and measures the result; callers do the checking.
   task automatic convert(input logic [6:0] v, output logic [11:0] res,
                          output int lat, output int busy_cnt, output bit bcd_stable);
      logic [11:0] prev;
      bit seen;
      @(negedge clk);
      start = 1'b1;
      bin   = v;
      prev  = bcd;
      @(negedge clk);
      start = 1'b0;
      bin   = 7'($urandom);
      lat = 0; busy_cnt = 0; seen = 0; bcd_stable = 1; res = '0;
      for (int j = 0; j < 20 && !seen; j++) begin
         if (busy) busy_cnt++;
         if (done) begin
            seen = 1;
            res  = bcd;
         end else begin
            if (bcd !== prev) bcd_stable = 0;
            @(negedge clk);
            lat++;
         end
      end
      if (!seen) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; bin = 7'd99;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_vec++;
         if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            $display("FAIL reset_hold: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd);
            n_err++;
         end
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
         $display("FAIL reset_release: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd);
         n_err++;
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_idle: cycle %0d busy=%b done=%b, required 0 0", c, busy, done);
            n_err++;
         end
      end
   endtask

   task automatic test_basic;
      logic [6:0]  vals [4] = '{7'd0, 7'd99, 7'd127, 7'd10};
      logic [11:0] res;
      int lat, bc;
      bit stable;
      for (int k = 0; k < 4; k++) begin
         convert(vals[k], res, lat, bc, stable);
         n_vec++;
         if (res !== ref_bcd(int'(vals[k]))) begin
            $display("FAIL basic_bcd: bin=%0d bcd=%h, required %h", vals[k], res, ref_bcd(int'(vals[k])));
            n_err++;
         end
         n_vec++;
         if (lat != 8) begin
            $display("FAIL basic_latency: bin=%0d latency=%0d, required 8", vals[k], lat);
            n_err++;
         end
         n_vec++;
         if (bc != 8) begin
            $display("FAIL basic_busy: bin=%0d busy cycles=%0d, required 8", vals[k], bc);
            n_err++;
         end
         n_vec++;
         if (!stable) begin
            $display("FAIL basic_bcd_hold: bin=%0d bcd changed before done, required held", vals[k]);
            n_err++;
         end
         @(negedge clk);
         n_vec++;
         if (done !== 1'b0) begin
            $display("FAIL basic_done_width: bin=%0d done=%b one cycle later, required 0", vals[k], done);
            n_err++;
         end
      end
   endtask

   task automatic test_sweep;
      logic [11:0] res;
      int lat, bc;
      bit stable;
      for (int v = 0; v < 128; v++) begin
         convert(7'(v), res, lat, bc, stable);
         n_vec++;
         if (res !== ref_bcd(v) || lat != 8) begin
            $display("FAIL sweep: bin=%0d bcd=%h latency=%0d, required %h latency 8", v, res, lat, ref_bcd(v));
            n_err++;
         end
      end
   endtask

   task automatic test_random;
      logic [11:0] res;
      int lat, bc, v;
      bit stable;
      for (int k = 0; k < 30; k++) begin
         v = int'($urandom_range(0, 127));
         convert(7'(v), res, lat, bc, stable);
         n_vec++;
         if (res !== ref_bcd(v) || lat != 8 || bc != 8) begin
            $display("FAIL random: bin=%0d bcd=%h lat=%0d busy=%0d, required %h 8 8", v, res, lat, bc, ref_bcd(v));
            n_err++;
         end
      end
   endtask

   task automatic test_ignored_start;
      int n_done = 0;
      logic [11:0] got = '0;
      @(negedge clk); start = 1'b1; bin = 7'd45;
      @(negedge clk); start = 1'b0; bin = 7'($urandom);
      @(negedge clk);
      @(negedge clk); start = 1'b1; bin = 7'd7;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 22; c++) begin
         if (done) begin
            n_done++;
            got = bcd;
         end
         @(negedge clk);
      end
      n_vec++;
      if (n_done != 1) begin
         $display("FAIL ignored_start_count: done pulses=%0d, required 1", n_done);
         n_err++;
      end
      n_vec++;
      if (got !== 12'h045) begin
         $display("FAIL ignored_start_bcd: bcd=%h, required 045", got);
         n_err++;
      end
   endtask

   task automatic test_back_to_back;
      int n_done = 0;
      int last = 0;
      bit prev_done = 0;
      @(negedge clk); start = 1'b1; bin = 7'd58;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            n_vec++;
            if (bcd !== 12'h058 || c - last != 9 || prev_done) begin
               $display("FAIL back_to_back: cycle %0d bcd=%h gap=%0d prev_done=%b, required 058 gap 9 prev 0",
                        c, bcd, c - last, prev_done);
               n_err++;
            end
            last = c;
         end
         prev_done = done;
      end
      n_vec++;
      if (n_done != 4) begin
         $display("FAIL back_to_back_count: done pulses=%0d, required 4", n_done);
         n_err++;
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [11:0] res;
      int lat, bc;
      bit stable;
      bit bad = 0;
      @(negedge clk); start = 1'b1; bin = 7'd88;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      n_vec++;
      if (bcd !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL reset_mid: busy=%b done=%b bcd=%h, required 0 0 000", busy, done, bcd);
         n_err++;
      end
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      n_vec++;
      if (bad) begin
         $display("FAIL reset_mid_quiet: activity after abort, required busy=0 done=0");
         n_err++;
      end
      convert(7'd21, res, lat, bc, stable);
      n_vec++;
      if (res !== 12'h021 || lat != 8) begin
         $display("FAIL reset_mid_next: bcd=%h latency=%0d, required 021 latency 8", res, lat);
         n_err++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bin = '0;
      test_reset();
      test_basic();
      test_sweep();
      test_random();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_serial.md
# bin_to_bcd_serial

Sequential binary-to-BCD converter that feeds the two-digit seven-segment scanner. It accepts a WIDTH-bit unsigned binary value on a start strobe and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents DIGITS packed BCD digits with a one-cycle done pulse. The display stage consumes bcd[3:0] as the ones digit and bcd[7:4] as the tens digit.

## Interface
- WIDTH, 7: width of the binary input.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1; the default 3 covers 0..127.
- CLK100MHZ  in  1  system clock. All state updates on its rising edge.
- RST  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  conversion request. Sampled only in IDLE.
- bin  in  WIDTH  unsigned binary operand. Sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress (states SHIFT and FINISH).
- done  out  1  one-cycle pulse; bcd is updated on the same edge.
- bcd  out  4*DIGITS  packed result. bcd[3:0] is ones, bcd[7:4] is tens, bcd[11:8] is hundreds. Held until the next done.

## Operation
- Internal registers:
  - state: IDLE, SHIFT, FINISH.
  - bin_sr: WIDTH bits, holds the remaining operand bits.
  - scratch: 4*DIGITS bits, accumulating BCD value.
  - cnt: ceil(log2(WIDTH+1)) bits, remaining shift count.
- RST high at an edge:
  - Outputs: busy=0, done=0, bcd=0.
  - Internal: state=IDLE, scratch=0, bin_sr=0, cnt=0.
  - RST overrides start and any in-progress conversion. A conversion aborted by reset produces no done.
- IDLE:
  - done is forced to 0 on every edge after its pulse.
  - If start=1, then on the edge: bin_sr←bin, scratch←0, cnt←WIDTH, busy←1, state←SHIFT.
  - If start=0, nothing changes; bcd holds.
- SHIFT, each edge:
  - Correction, combinational and applied to all digits in parallel: every 4-bit digit of scratch that is ≥5 has 3 added. Additions are 4-bit and cannot carry between digits.
  - Shift: {scratch, bin_sr} ← {corrected_scratch, bin_sr} << 1. The MSB of bin_sr enters scratch bit 0.
  - cnt←cnt−1. When cnt==1 on this edge, state←FINISH.
- FINISH, one edge: bcd←scratch, done←1, busy←0, state←IDLE.
- Correction is never applied after the final shift.
- start is ignored while busy=1. A changing bin during conversion has no effect.
- start high for multiple cycles in IDLE starts exactly one conversion per IDLE visit. If start is still high on the edge after done, a new conversion begins (back-to-back).
- Input values:
  - All 2^WIDTH input values are legal.
  - Unused upper BCD digits read 0. For example, bin=42 gives bcd=12'h042.

## Timing
- Start accepted at edge E0 (the end of cycle 0). busy is high from cycle 1 through cycle WIDTH+1.
- SHIFT occupies edges E1..E_WIDTH. FINISH is at edge E_{WIDTH+1}.
- done=1 and the new bcd appear in cycle WIDTH+2; busy=0 in that same cycle.
- Latency from the start-sample edge to done visible is WIDTH+1 edges: 8 for WIDTH=7.
- Throughput is one conversion per WIDTH+2 cycles with start held high continuously (9 cycles for WIDTH=7).
- done is exactly one cycle wide. It is never asserted while busy=1.
- bcd changes only on an edge where done goes high, or on reset.
- Outputs are registered; there is no combinational path from start or bin to any output.

## Test plan
- Reset values: assert RST for 2 cycles with start=1 and bin=99. Required: busy=0, done=0, bcd=0 throughout and on the first cycle after release; no done afterwards unless start is re-sampled.
- Basic conversions, each a single start pulse:
  - bin=0 gives bcd=12'h000.
  - bin=99 gives bcd=12'h099.
  - bin=127 gives bcd=12'h127.
  - bin=10 gives bcd=12'h010.
  - For every case: done arrives exactly 8 edges after the accepting edge, and busy is high for exactly 8 cycles.
- Exhaustive sweep: bin=0..127 in sequence. Every bcd matches the decimal value of bin; digits above the value's magnitude are 0.
- Ignored start: start with bin=45, then pulse start with bin=7 at cycle 3. Required: a single done with bcd=12'h045; the second pulse produces nothing.
- Back-to-back: hold start=1 with bin=58 constant. Required: done pulses every 9 cycles, each with bcd=12'h058; done is never 2 cycles wide.
- Reset mid-conversion: start with bin=88 and assert RST at cycle 4. Required: bcd=0, busy=0, no done. A following start with bin=21 yields bcd=12'h021 with normal latency.
